// File: rtl/eqn_tt_pkg.sv
// Shared types and sizes for the (P+Q').(R'+D) truth-table sweeper.
// Holds the FSM encoding, the vector count and the counter widths used by the top and its bench.
package eqn_tt_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = $clog2(NUM_VECTORS);
  localparam int ERR_W       = $clog2(NUM_VECTORS + 1);
  localparam int SETTLE_W    = 4;

  localparam logic [VEC_W-1:0] LAST_VEC = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/eqn_tt_sweeper_if.sv
// Stimulus/result bundle between the sweeper (master) and whatever drives start and observes results (slave).
interface eqn_tt_sweeper_if;

  logic                           start_i;
  logic                           y_i;
  logic                           p_o;
  logic                           q_o;
  logic                           r_o;
  logic                           d_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           pass_o;
  logic [eqn_tt_pkg::ERR_W-1:0]   err_cnt_o;
  logic [eqn_tt_pkg::VEC_W-1:0]   first_fail_o;
  logic                           first_fail_vld_o;

  modport master (
    input  start_i, y_i,
    output p_o, q_o, r_o, d_o, busy_o, done_o, pass_o,
           err_cnt_o, first_fail_o, first_fail_vld_o
  );

  modport slave (
    output start_i, y_i,
    input  p_o, q_o, r_o, d_o, busy_o, done_o, pass_o,
           err_cnt_o, first_fail_o, first_fail_vld_o
  );

endinterface

// File: rtl/eqn_tt_sweeper_golden.sv
// Golden model of the equation under test: exp = (p | ~q) & (~r | d).
// Purely combinational, zero latency.
module eqn_golden (
  input  logic p,
  input  logic q,
  input  logic r,
  input  logic d,
  output logic exp
);

  assign exp = (p | ~q) & (~r | d);

endmodule

// File: rtl/eqn_tt_sweeper.sv
// Sweeps all 16 {p,q,r,d} vectors into an external equation stage and scores y_i against eqn_golden.
// Each vector takes SETTLE_CYCLES+2 cycles; TT_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module eqn_tt_sweeper
  import eqn_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  eqn_tt_sweeper_if.master bus
);

`ifdef TT_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state, state_nxt;
  logic [VEC_W-1:0]    vec, vec_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [ERR_W-1:0]    err_cnt, err_nxt;
  logic [VEC_W-1:0]    first_fail, first_fail_nxt;
  logic                first_fail_vld, first_fail_vld_nxt;
  logic                pass, pass_nxt;
  logic [VEC_W-1:0]    stim;
  logic                exp_bit;
  logic                mismatch;
  logic                sweeping_nxt;

  eqn_golden u_golden (
    .p   (vec[3]),
    .q   (vec[2]),
    .r   (vec[1]),
    .d   (vec[0]),
    .exp (exp_bit)
  );

  assign mismatch     = (bus.y_i != exp_bit);
  assign sweeping_nxt = (state_nxt == APPLY) || (state_nxt == SETTLE) || (state_nxt == SAMPLE);

  always_comb begin
    state_nxt          = state;
    vec_nxt            = vec;
    settle_nxt         = settle_cnt;
    err_nxt            = err_cnt;
    first_fail_nxt     = first_fail;
    first_fail_vld_nxt = first_fail_vld;
    pass_nxt           = pass;

    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_nxt          = APPLY;
          vec_nxt            = '0;
          err_nxt            = '0;
          first_fail_vld_nxt = 1'b0;
          pass_nxt           = 1'b0;
        end
      end
      APPLY: begin
        settle_nxt = '0;
        state_nxt  = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_nxt = err_cnt + 1'b1;
          if (!first_fail_vld) begin
            first_fail_nxt     = vec;
            first_fail_vld_nxt = 1'b1;
          end
        end
        // pass is decided on the way into DONE so it is already valid while done_o is high
        if ((STOP_ON_FAIL && mismatch) || (vec == LAST_VEC)) begin
          state_nxt = DONE;
          pass_nxt  = (err_nxt == '0);
        end else begin
          vec_nxt   = vec + 1'b1;
          state_nxt = APPLY;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      vec            <= '0;
      settle_cnt     <= '0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
      stim           <= '0;
    end else begin
      state          <= state_nxt;
      vec            <= vec_nxt;
      settle_cnt     <= settle_nxt;
      err_cnt        <= err_nxt;
      first_fail     <= first_fail_nxt;
      first_fail_vld <= first_fail_vld_nxt;
      pass           <= pass_nxt;
      stim           <= sweeping_nxt ? vec_nxt : '0;
    end
  end

  assign bus.p_o              = stim[3];
  assign bus.q_o              = stim[2];
  assign bus.r_o              = stim[1];
  assign bus.d_o              = stim[0];
  assign bus.busy_o           = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
  assign bus.done_o           = (state == DONE);
  assign bus.pass_o           = pass;
  assign bus.err_cnt_o        = err_cnt;
  assign bus.first_fail_o     = first_fail;
  assign bus.first_fail_vld_o = first_fail_vld;

endmodule

// File: tb/tb_eqn_tt_sweeper.sv
// Bench for eqn_tt_sweeper: an emulated equation stage with a per-vector fault mask drives y_i,
// sweeps are scored by a queue-based scoreboard; honours TT_STOP_ON_FAIL_EN.
module tb_eqn_tt_sweeper;

  localparam int S         = 2;
  localparam int VEC_EDGES = S + 2;

  typedef struct {
    int err;
    int ff;
    bit ffv;
    bit pass;
    int start_edge;
    int latency;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mask = '0;
  logic [15:0] exp_tbl;
  logic [3:0]  idx;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eqn_tt_sweeper_if bus ();

  eqn_tt_sweeper #(.SETTLE_CYCLES(S)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Emulated equation stage: correct output except where the fault mask flips it.
  assign idx     = {bus.p_o, bus.q_o, bus.r_o, bus.d_o};
  assign bus.y_i = exp_tbl[idx] ^ mask[idx];

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] m, input int start_edge);
    exp_t e;
    int   n     = 0;
    int   first = -1;
    for (int v = 0; v < 16; v++) begin
      if (m[v]) begin
        n++;
        if (first < 0) first = v;
      end
    end
`ifdef TT_STOP_ON_FAIL_EN
    e.err     = (n > 0) ? 1 : 0;
    e.latency = ((first < 0) ? 16 : first + 1) * VEC_EDGES;
`else
    e.err     = n;
    e.latency = 16 * VEC_EDGES;
`endif
    e.ffv        = (first >= 0);
    e.ff         = (first < 0) ? 0 : first;
    e.pass       = (n == 0);
    e.start_edge = start_edge;
    return e;
  endfunction

  // Monitor: scores every done_o pulse against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc - e.start_edge, e.latency);
          check("err_cnt", int'(bus.err_cnt_o), e.err);
          check("pass", int'(bus.pass_o), int'(e.pass));
          check("first_fail_vld", int'(bus.first_fail_vld_o), int'(e.ffv));
          if (e.ffv) check("first_fail", int'(bus.first_fail_o), e.ff);
          check("busy_in_done", int'(bus.busy_o), 0);
          check("stim_in_done", int'(idx), 0);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(bus.busy_o), 0);
    check({tag, "_done"}, int'(bus.done_o), 0);
    check({tag, "_pass"}, int'(bus.pass_o), 0);
    check({tag, "_err"}, int'(bus.err_cnt_o), 0);
    check({tag, "_ff"}, int'(bus.first_fail_o), 0);
    check({tag, "_ffv"}, int'(bus.first_fail_vld_o), 0);
    check({tag, "_stim"}, int'(idx), 0);
  endtask

  task automatic run_sweep(input logic [15:0] m, input bit repulse);
    exp_t e;
    int   se;
    int   budget;
    mask = m;
    @(negedge clk);
    bus.start_i = 1'b1;
    se = cyc + 1;
    e  = model(m, se);
    sb.push_back(e);
    @(negedge clk);
    bus.start_i = 1'b0;
    if (repulse) begin
      while (cyc < se + 9) @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check("hold_done", int'(bus.done_o), 0);
    check("hold_busy", int'(bus.busy_o), 0);
    check("hold_stim", int'(idx), 0);
    check("hold_err", int'(bus.err_cnt_o), e.err);
    check("hold_pass", int'(bus.pass_o), int'(e.pass));
    check("hold_ffv", int'(bus.first_fail_vld_o), int'(e.ffv));
    if (e.ffv) check("hold_ff", int'(bus.first_fail_o), e.ff);
  endtask

  task automatic reset_mid_sweep();
    int budget;
    mask = 16'h0000;
    @(negedge clk);
    bus.start_i = 1'b1;
    sb.push_back(model(mask, cyc + 1));
    @(negedge clk);
    bus.start_i = 1'b0;
    budget = 0;
    while (!(bus.busy_o && idx == 4'd5) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("reach_vec5", int'(bus.busy_o && idx == 4'd5), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check_idle("mid_rst");
    repeat (2) @(negedge clk);
    check("mid_rst_stays_idle", int'(bus.busy_o), 0);
  endtask

  initial begin
    logic [15:0] m;
    bus.start_i = 1'b0;
    for (int v = 0; v < 16; v++) begin
      exp_tbl[v] = ((v >> 3) & 1) || !((v >> 2) & 1);
      exp_tbl[v] = exp_tbl[v] && (!((v >> 1) & 1) || (v & 1));
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    run_sweep(16'h0000, 1'b1);   // correct stage, start re-pulsed mid-sweep
    run_sweep(exp_tbl, 1'b0);    // y stuck at 0
    run_sweep(~exp_tbl, 1'b0);   // y stuck at 1
    reset_mid_sweep();
    run_sweep(16'h0000, 1'b0);

    // reset wins over a coincident start
    @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    check("rst_priority_busy", int'(bus.busy_o), 0);
    @(negedge clk);
    check("rst_priority_idle", int'(bus.busy_o), 0);

    for (int i = 0; i < 8; i++) begin
      case (i % 3)
        0:       m = 16'($urandom);
        1:       m = 16'h0001 << $urandom_range(15);
        default: m = 16'h8000;
      endcase
      run_sweep(m, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eqn_tt_sweeper.md
EQN_TT_SWEEPER -- requirements
Module: eqn_tt_sweeper

Interface
REQ-001 Clocking SHALL be one clock with a synchronous, active-high reset: clk_i rises, rst_i is sampled on clk_i.
REQ-002 Parameter SETTLE_CYCLES, default 2: cycles between applying a vector and sampling y_i. Legal range 1..15.
REQ-003 clk_i  input  1  clock.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 start_i  input  1  starts a full truth-table sweep.
REQ-006 p_o, q_o, r_o, d_o  output  1 each  stimulus to the downstream (P+Q').(R'+D) equation stage.
REQ-007 y_i  input  1  equation-stage output to be checked.
REQ-008 busy_o  output  1  sweep in progress.
REQ-009 done_o  output  1  one-cycle sweep-complete pulse.
REQ-010 pass_o  output  1  last sweep had zero mismatches.
REQ-011 err_cnt_o  output  5  mismatch count, 0..16.
REQ-012 first_fail_o  output  4  index of the first failing vector.
REQ-013 first_fail_vld_o  output  1  first_fail_o is valid.

Function
REQ-014 The vector index SHALL be vec[3:0] = {p,q,r,d}, swept from 0 to 15 in ascending order.
REQ-015 The expected value SHALL be exp = (p | ~q) & (~r | d), evaluated on the current vec.
REQ-016 The FSM states SHALL be IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-017 IDLE SHALL behave as follows:
- start_i=1 -> APPLY, with vec=0, err_cnt_o=0, first_fail_vld_o=0, pass_o=0.
- Otherwise remain in IDLE.
REQ-018 APPLY SHALL last 1 cycle and then go to SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to SAMPLE.
REQ-020 SAMPLE SHALL last 1 cycle and perform the following:
- If y_i != exp: err_cnt_o increments.
- On the first mismatch, first_fail_o=vec and first_fail_vld_o=1.
- If vec==15: go to DONE.
- Otherwise: vec+1 and go to APPLY.
REQ-021 DONE SHALL last 1 cycle, then go to IDLE.
REQ-022 p_o..d_o SHALL be registered from vec and held stable from APPLY through SAMPLE.
REQ-023 p_o..d_o SHALL be 0 in IDLE and DONE.
REQ-024 busy_o SHALL be 1 in APPLY, SETTLE and SAMPLE, and 0 otherwise.
REQ-025 done_o SHALL be 1 only in DONE, which is entered 16*(SETTLE_CYCLES+2) rising edges after the edge that samples start_i.
REQ-026 pass_o SHALL be set in DONE when err_cnt_o==0.
REQ-027 pass_o, err_cnt_o, first_fail_o and first_fail_vld_o SHALL hold their values until the next accepted start_i.
REQ-028 start_i asserted while busy_o=1 or in DONE SHALL be ignored, with no restart.
REQ-029 err_cnt_o SHALL be 5 bits wide and need no saturation, since its maximum is 16.

Reset
REQ-030 rst_i=1 at any clk_i edge, including mid-sweep, SHALL force IDLE, with the following outputs all 0:
- vec and the settle counter;
- p_o..d_o;
- busy_o and done_o;
- pass_o;
- err_cnt_o;
- first_fail_o and first_fail_vld_o.
REQ-031 rst_i SHALL take priority over start_i in the same cycle.

Configuration
REQ-032 The macro TT_STOP_ON_FAIL_EN SHALL control stop-on-fail behaviour:
- Defined: the first mismatch in SAMPLE goes directly to DONE (err_cnt_o=1, pass_o=0) and the remaining vectors are skipped.
- Undefined: all 16 vectors are always swept.

Structure
REQ-033 A shared package/include eqn_tt_pkg SHALL hold the following:
- FSM state encodings;
- NUM_VECTORS=16;
- LAST_VEC=4'd15;
- the counter widths.
REQ-034 The expected function SHALL be a separate combinational sub-module eqn_golden (inputs p,q,r,d; output exp), instanced once.
REQ-035 Implementation SHALL be a single clocked process plus combinational next-state logic, with no latches.

Verification (SETTLE_CYCLES=2 unless noted)
REQ-036 Correct equation stage connected, start_i pulse -> done_o at edge 64 after start, pass_o=1, err_cnt_o=0, first_fail_vld_o=0.
REQ-037 y_i tied 0 -> err_cnt_o=9, first_fail_o=0, first_fail_vld_o=1, pass_o=0.
REQ-038 y_i tied 1 -> err_cnt_o=7, first_fail_o=2.
REQ-039 With TT_STOP_ON_FAIL_EN and y_i tied 1 -> DONE reached at edge 12, err_cnt_o=1, first_fail_o=2.
REQ-040 Reset and restart:
- rst_i asserted while vec=5 -> next cycle all outputs 0 and state IDLE.
- A following start_i then completes a normal sweep, with done_o at edge 64.
REQ-041 start_i re-pulsed at edge 10 of a sweep -> ignored, and done_o still occurs at edge 64.
